// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - bus between the multicycle control FSM and its datapath
interface mc_control_if;
  // datapath -> controller
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  // controller -> datapath
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  // datapath side
  modport master (
    output op, zero, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           instr_done, illegal_op, state
  );

  // controller side
  modport slave (
    input  op, zero, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - Moore control FSM for a multicycle MIPS-style datapath
module mc_control (
  input  logic        clk,
  input  logic        reset_n,
  mc_control_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       instr_done;
  logic       illegal_op;

  assign op        = bus.op;
  assign zero      = bus.zero;
  assign mem_ready = bus.mem_ready;

  // state register; reset is asynchronous so a stalled access can be aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and Moore outputs; unlisted strobes stay 0, unused codes recover to FETCH
  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        // PC+4 through the ALU; IR and PC load only when the read returns
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // branch target precomputed while the opcode is dispatched
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        // the store completes, and the instruction ends, on the ready cycle
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        // compare via subtract; PC takes the target held in ALUOut when equal
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.pc_src     = pc_src;
  assign bus.pc_en      = pc_en;
  assign bus.instr_done = instr_done;
  assign bus.illegal_op = illegal_op;
  assign bus.state      = state_q;

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
- REQ-001: Parameters: none; opcodes fixed (R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, ADDI=6'b001000, J=6'b000010).
- REQ-002: clk  input  1  single system clock, rising-edge.
- REQ-003: reset_n  input  1  asynchronous, active-low reset.
- REQ-004: op  input  6  opcode field of the instruction register.
- REQ-005: zero  input  1  ALU zero flag.
- REQ-006: mem_ready  input  1  memory access complete this cycle.
- REQ-007: iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath strobes/selects.
- REQ-008: alu_src_b, alu_op, pc_src  output  2 each  selects; pc_src drives the PC-source 3:1 mux (0=ALUResult, 1=ALUOut, 2=jump target).
- REQ-009: pc_en  output  1  PC register load enable.
- REQ-010: instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- REQ-011: illegal_op  output  1  one-cycle pulse on decode of an unsupported opcode.
- REQ-012: state  output  4  current state code, for debug.

Function
- REQ-013: Moore FSM with encodings RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12; codes 13-15 go to FETCH on the next edge with all outputs 0.
- REQ-014: All outputs are combinational from state, op, zero and mem_ready only; any output not listed for a state is 0.
- REQ-015: Transitions: RESET->FETCH unconditionally; FETCH->DECODE on mem_ready, else hold.
- REQ-016: DECODE dispatch: LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, any other op->FETCH.
- REQ-017: MEMADR->MEMRD if op==LW, else ->MEMWR; MEMRD->MEMWB on mem_ready, else hold; MEMWR->FETCH on mem_ready, else hold.
- REQ-018: EXEC->ALUWB and ADDIEX->ADDIWB; MEMWB, ALUWB, BRANCH, ADDIWB and JUMP each ->FETCH.
- REQ-019: FETCH: mem_read=1, alu_src_b=01, ir_write=mem_ready, pc_en=mem_ready (pc_src=00).
- REQ-020: DECODE: alu_src_b=11; illegal_op=1 when op is unsupported.
- REQ-021: MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10.
- REQ-022: MEMRD: iord=1, mem_read=1.
- REQ-023: MEMWR: iord=1, mem_write=1, instr_done=mem_ready.
- REQ-024: MEMWB: mem_to_reg=1, reg_write=1, instr_done=1.
- REQ-025: EXEC: alu_src_a=1, alu_op=10.
- REQ-026: ALUWB: reg_dst=1, reg_write=1, instr_done=1.
- REQ-027: ADDIWB: reg_write=1, instr_done=1.
- REQ-028: BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero, instr_done=1.
- REQ-029: JUMP: pc_src=10, pc_en=1, instr_done=1.
- REQ-030: pc_src is never 11.
- REQ-031: mem_read and mem_write are never both 1; reg_write and pc_en are never both 1.
- REQ-032: mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- REQ-033: A memory stall of any length holds state with strobes steady and no instr_done.
- REQ-034: op is sampled only in DECODE and MEMADR; zero is used only in BRANCH.
- REQ-035: Cycle counts with mem_ready tied high, FETCH to FETCH: R=4, ADDI=4, LW=5, SW=4, BEQ=3, J=3, illegal=2.

Reset
- REQ-036: reset_n low forces state=RESET immediately, without waiting for a clock edge, from any state including mid-stall.
- REQ-037: In RESET every output is 0 (state=0).
- REQ-038: The first clk edge after reset_n rises enters FETCH.

Verification
- REQ-039: Reset release, mem_ready=1, op=R -> states 0,1,2,7,8,1; reg_dst=1 and reg_write=1 in ALUWB; one instr_done pulse.
- REQ-040: LW with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout; then MEMWB with mem_to_reg=1, reg_write=1.
- REQ-041: BEQ with zero=1 -> pc_en=1, pc_src=01 in BRANCH; repeat with zero=0 -> pc_en=0; both return to FETCH.
- REQ-042: J -> pc_src=10, pc_en=1 in JUMP; op=6'b111111 -> illegal_op pulse in DECODE, then FETCH, with no reg_write or mem_write asserted.
- REQ-043: reset_n pulsed low mid-MEMWR during a stall -> state=0 and mem_write=0 before the next edge; FETCH one edge after release.
